abl17_alu_argus_pipe: RTL

Registered, parametrised-width successor to the fault-checked ALU. It accepts one operation per valid/ready handshake and executes it with concurrent checkers on the adder, SLL and SRA units. On a detected error it re-executes once with fault injection suppressed, and it reports the final result, its error status and sticky error statistics. It sits between the decode stage and writeback, and is the unit the fault-detection experiments drive.

---
 rtl/abl17_alu_pkg.sv | 32 +++
 rtl/abl17_mod3_residue.sv | 19 +
 rtl/abl17_alu_argus_pipe.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/abl17_alu_pkg.sv
// Shared constants for the argus ALU pipe: opcodes, FSM states, sticky-bit indices
// and the modulo-3 accumulate step used by the residue checker.
package abl17_alu_pkg;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_AND = 5'd2;
  localparam logic [4:0] OP_OR  = 5'd3;
  localparam logic [4:0] OP_SLL = 5'd4;
  localparam logic [4:0] OP_SRA = 5'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_RETRY = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int STK_ADDER = 0;
  localparam int STK_SRA   = 1;
  localparam int STK_SLL   = 2;

  // Adds two values in 0..3 and reduces modulo 3 (3 counts as 0).
  function automatic logic [1:0] mod3_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 3'd6)      return 2'd0;
    else if (s >= 3'd3) return 2'(s - 3'd3);
    else                return s[1:0];
  endfunction

endpackage

// File: rtl/abl17_mod3_residue.sv
// Residue modulo 3 of a WIDTH-bit value; 4^k == 1 (mod 3), so 2-bit digits simply add.
module abl17_mod3_residue
  import abl17_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  output logic [1:0]       residue
);

  always_comb begin
    residue = 2'd0;
    // NOTE: blocking '=' is intended: each step must see the accumulation of the previous one.
    for (int i = 0; i < WIDTH / 2; i++) begin
      residue = mod3_add(residue, value[2*i +: 2]);
    end
  end

endmodule

// File: rtl/abl17_alu_argus_pipe.sv
// Handshaked ALU with residue-checked adder and reference-checked shifters; a detected
// error triggers one clean re-execution, and errors are tallied in sticky statistics.
module abl17_alu_argus_pipe
  import abl17_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH),
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic [4:0]       ctrl_ALUopcode,
  input  logic [SHW-1:0]   ctrl_shiftamt,
  input  logic [1:0]       ctrl_fault_inject,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_result,
  output logic             isNotEqual,
  output logic             isLessThan,
  output logic             out_error,
  output logic             out_retried,
  output logic [2:0]       err_sticky,
  output logic [CNT_W-1:0] err_count,
  input  logic             clear_err
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic [4:0]       op_q;
  logic [SHW-1:0]   sh_q;
  logic [1:0]       fi_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
      sh_q <= '0;
      fi_q <= '0;
    end else if (state == ST_IDLE && in_valid) begin
      a_q  <= data_operandA;
      b_q  <= data_operandB;
      op_q <= ctrl_ALUopcode;
      sh_q <= ctrl_shiftamt;
      fi_q <= ctrl_fault_inject;
    end
  end

  // Adder path: injection is only live in EXEC so the retry runs clean.
  logic [1:0]       fi_eff;
  logic             is_sub, cout;
  logic [WIDTH-1:0] b_mux, sum_raw, sum, fault_mask;
  logic [1:0]       res_a, res_b, res_s;
  logic             adder_err;

  assign fi_eff     = (state == ST_EXEC) ? fi_q : 2'b00;
  assign is_sub     = (op_q == OP_SUB);
  assign b_mux      = is_sub ? ~b_q : b_q;
  assign {cout, sum_raw} = {1'b0, a_q} + {1'b0, b_mux} + (WIDTH+1)'(is_sub);
  assign fault_mask = ({WIDTH{fi_eff[1]}} & (WIDTH'(1) << (WIDTH / 2)))
                    | ({WIDTH{fi_eff[0]}} & (WIDTH'(1) << (WIDTH / 8)));
  assign sum        = sum_raw ^ fault_mask;

  abl17_mod3_residue #(.WIDTH(WIDTH)) u_res_a (.value(a_q),   .residue(res_a));
  abl17_mod3_residue #(.WIDTH(WIDTH)) u_res_b (.value(b_mux), .residue(res_b));
  abl17_mod3_residue #(.WIDTH(WIDTH)) u_res_s (.value(sum),   .residue(res_s));

  // 2^WIDTH == 1 (mod 3) for even WIDTH, so the carry-out adds straight into the sum residue.
  assign adder_err = mod3_add(mod3_add(res_a, res_b), {1'b0, is_sub})
                  != mod3_add(res_s, {1'b0, cout});

  // Functional shifters: stages apply distances 1, 2, 4, ... in ascending order.
  genvar gi;
  for (gi = 0; gi < SHW; gi++) begin : g_sh
    localparam int S = 2 ** gi;
    logic [WIDTH-1:0] sll_d, sra_d, sll_q, sra_q;
    if (gi == 0) begin : g_first
      assign sll_d = a_q;
      assign sra_d = a_q;
    end else begin : g_next
      assign sll_d = g_sh[gi-1].sll_q;
      assign sra_d = g_sh[gi-1].sra_q;
    end
    assign sll_q = sh_q[gi] ? {sll_d[WIDTH-1-S:0], {S{1'b0}}} : sll_d;
    assign sra_q = sh_q[gi] ? {{S{a_q[WIDTH-1]}}, sra_d[WIDTH-1:S]} : sra_d;
  end

  // Reference shifters walk the distances in descending order, so a stuck stage differs.
  for (gi = 0; gi < SHW; gi++) begin : g_ref
    localparam int K = SHW - 1 - gi;
    localparam int S = 2 ** K;
    logic [WIDTH-1:0] sll_d, sra_d, sll_q, sra_q;
    if (gi == 0) begin : g_first
      assign sll_d = a_q;
      assign sra_d = a_q;
    end else begin : g_next
      assign sll_d = g_ref[gi-1].sll_q;
      assign sra_d = g_ref[gi-1].sra_q;
    end
    assign sll_q = sh_q[K] ? {sll_d[WIDTH-1-S:0], {S{1'b0}}} : sll_d;
    assign sra_q = sh_q[K] ? {{S{a_q[WIDTH-1]}}, sra_d[WIDTH-1:S]} : sra_d;
  end

  logic [WIDTH-1:0] sll_res, sra_res, alu_res;
  logic [2:0]       err_bits;
  logic             unit_err, ne, lt;

  assign sll_res = g_sh[SHW-1].sll_q;
  assign sra_res = g_sh[SHW-1].sra_q;

  assign err_bits[STK_ADDER] = (op_q == OP_ADD || op_q == OP_SUB) && adder_err;
  assign err_bits[STK_SRA]   = (op_q == OP_SRA) && (sra_res != g_ref[SHW-1].sra_q);
  assign err_bits[STK_SLL]   = (op_q == OP_SLL) && (sll_res != g_ref[SHW-1].sll_q);
  assign unit_err            = |err_bits;

  assign ne = |sum;
  assign lt = (a_q[WIDTH-1] & ~b_q[WIDTH-1]) | (sum[WIDTH-1] & (a_q[WIDTH-1] ~^ b_q[WIDTH-1]));

  always_comb begin
    alu_res = '0;
    case (op_q)
      OP_ADD, OP_SUB: alu_res = sum;
      OP_AND:         alu_res = a_q & b_q;
      OP_OR:          alu_res = a_q | b_q;
      OP_SLL:         alu_res = sll_res;
      OP_SRA:         alu_res = sra_res;
      default:        alu_res = '0;
    endcase
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      ST_IDLE:  if (in_valid) state_nxt = ST_EXEC;
      ST_EXEC:  state_nxt = unit_err ? ST_RETRY : ST_DONE;
      ST_RETRY: state_nxt = ST_DONE;
      ST_DONE:  if (out_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    // NOTE: '<=' for state so every register samples the values from before the edge.
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  logic load_result, detect;
  assign load_result = (state == ST_EXEC && !unit_err) || state == ST_RETRY;
  assign detect      = unit_err && (state == ST_EXEC || state == ST_RETRY);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_result <= '0;
      isNotEqual  <= 1'b0;
      isLessThan  <= 1'b0;
      out_error   <= 1'b0;
      out_retried <= 1'b0;
    end else if (load_result) begin
      data_result <= alu_res;
      isNotEqual  <= ne;
      isLessThan  <= lt;
      out_error   <= (state == ST_RETRY) && unit_err;
      out_retried <= (state == ST_RETRY);
    end
  end

  // A clear coinciding with a new error starts the statistics from that error.
  logic [CNT_W-1:0] cnt_base;
  logic [2:0]       stk_base;
  assign cnt_base = clear_err ? '0 : err_count;
  assign stk_base = clear_err ? '0 : err_sticky;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_count  <= '0;
      err_sticky <= '0;
    end else if (detect) begin
      err_count  <= (&cnt_base) ? cnt_base : cnt_base + 1'b1;
      err_sticky <= stk_base | err_bits;
    end else if (clear_err) begin
      err_count  <= '0;
      err_sticky <= '0;
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

endmodule
